reset_ctrl: RTL and testbench

Board reset controller sitting directly downstream of the watchdog in the CPLD. It turns watchdog bite strobes, the reset push-button and a keyed software request into one timed, active-low SoC reset pulse. It latches the failsafe boot selection at the moment of the bite and records sticky reset causes plus a saturating reset count in the shared CSR space.

---
 rtl/reset_ctrl_pkg.sv | 27 ++
 rtl/reset_ctrl_debounce.sv | 42 ++++
 rtl/reset_ctrl.sv | 174 +++++++++++++++++
 tb/tb_reset_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_ctrl_pkg.sv
// Shared definitions for the board reset controller: CSR offsets, cause bit
// positions and FSM state encoding.
package reset_ctrl_pkg;

    localparam logic [4:0] R_CAUSE = 5'h0;
    localparam logic [4:0] R_SWRST = 5'h1;
    localparam logic [4:0] R_COUNT = 5'h2;

    localparam int CAUSE_WDT0 = 0;
    localparam int CAUSE_WDT1 = 1;
    localparam int CAUSE_BTN  = 2;
    localparam int CAUSE_SW   = 3;
    localparam int CAUSE_POR  = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    // Offsets wrap inside the 5-bit CSR window.
    function automatic logic csr_hit(input logic [4:0] addr, input logic [4:0] base,
                                     input logic [4:0] offs);
        logic [4:0] target;
        target = base + offs;
        return addr == target;
    endfunction

endpackage

// File: rtl/reset_ctrl_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a ce-tick stability
// counter; the output level only follows after LEN stable ticks.
module debounce #(
    parameter logic [3:0] LEN = 4'd10
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_reg;
    logic       level_reg;
    logic [3:0] stab_reg;
    logic [4:0] stab_inc;

    assign stab_inc = {1'b0, stab_reg} + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg  <= 2'b11;
            level_reg <= 1'b1;
            stab_reg  <= 4'd0;
        end else begin
            sync_reg <= {sync_reg[0], din};
            if (sync_reg[1] == level_reg) begin
                stab_reg <= 4'd0;
            end else if (ce) begin
                if (stab_inc >= {1'b0, LEN}) begin
                    level_reg <= sync_reg[1];
                    stab_reg  <= 4'd0;
                end else begin
                    stab_reg <= stab_inc[3:0];
                end
            end
        end
    end

    assign dout = level_reg;

endmodule

// File: rtl/reset_ctrl.sv
// Board reset controller: watchdog/button/software triggers to a timed SoC reset.
// Optional button debounce enabled by defining RESET_CTRL_DEBOUNCE_EN.
module reset_ctrl
    import reset_ctrl_pkg::*;
#(
    parameter logic [4:0] BASE_ADDR    = 5'h0,
    parameter logic [7:0] PULSE_LEN    = 8'd100,
    parameter logic [7:0] HOLDOFF_LEN  = 8'd20,
    parameter logic [7:0] SWRST_KEY    = 8'hc5,
    parameter logic [3:0] DEBOUNCE_LEN = 4'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       pwr_is_off,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic [1:0] wdt_strobe,
    input  logic       failsafe_mode,
    input  logic       btn_rst_n,
    output logic       soc_rst_n,
    output logic       failsafe_boot,
    output logic       rst_active
);

    localparam logic [7:0] PULSE_EFF = (PULSE_LEN == 8'd0) ? 8'd1 : PULSE_LEN;

    logic       btn_level;
    logic       btn_prev_reg;
    logic [1:0] state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       fsb_reg, fsb_next;
    logic       soc_rst_n_reg;
    logic [4:0] cause_reg, cause_next;
    logic [7:0] count_reg, count_next;
    logic [4:0] trig_vec;
    logic       trig_any;
    logic       hit_cause, hit_swrst, hit_count;

`ifdef RESET_CTRL_DEBOUNCE_EN
    debounce #(
        .LEN (DEBOUNCE_LEN)
    ) u_debounce (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .din  (btn_rst_n),
        .dout (btn_level)
    );
`else
    logic [1:0] btn_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_sync_reg <= 2'b11;
        end else begin
            btn_sync_reg <= {btn_sync_reg[0], btn_rst_n};
        end
    end

    assign btn_level = btn_sync_reg[1];
`endif

    assign hit_cause = csr_hit(csr_a, BASE_ADDR, R_CAUSE);
    assign hit_swrst = csr_hit(csr_a, BASE_ADDR, R_SWRST);
    assign hit_count = csr_hit(csr_a, BASE_ADDR, R_COUNT);

    assign trig_vec[CAUSE_WDT0] = wdt_strobe[0];
    assign trig_vec[CAUSE_WDT1] = wdt_strobe[1];
    assign trig_vec[CAUSE_BTN]  = btn_prev_reg & ~btn_level;
    assign trig_vec[CAUSE_SW]   = csr_we & hit_swrst & (csr_di == SWRST_KEY);
    assign trig_vec[CAUSE_POR]  = 1'b0;
    assign trig_any = |trig_vec;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        fsb_next   = fsb_reg;
        if (pwr_is_off) begin
            state_next = ST_ASSERT;
            cnt_next   = PULSE_EFF;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (trig_any) begin
                        state_next = ST_ASSERT;
                        cnt_next   = PULSE_EFF;
                        fsb_next   = failsafe_mode;
                    end
                end
                ST_ASSERT: begin
                    if (ce) begin
                        if (cnt_reg <= 8'd1) begin
                            state_next = ST_HOLDOFF;
                            cnt_next   = HOLDOFF_LEN;
                        end else begin
                            cnt_next = cnt_reg - 8'd1;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    // A zero-length holdoff drops straight back to IDLE.
                    if (cnt_reg == 8'd0) begin
                        state_next = ST_IDLE;
                    end else if (ce) begin
                        cnt_next = cnt_reg - 8'd1;
                        if (cnt_reg == 8'd1) begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        cause_next = cause_reg;
        if (csr_we && hit_cause) begin
            cause_next = cause_reg & ~csr_di[4:0];
        end
        cause_next = cause_next | trig_vec;

        count_next = count_reg;
        if (trig_any) begin
            if (csr_we && hit_count) begin
                count_next = 8'd1;
            end else if (count_reg != 8'hff) begin
                count_next = count_reg + 8'd1;
            end
        end else if (csr_we && hit_count) begin
            count_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_ASSERT;
            cnt_reg       <= PULSE_EFF;
            fsb_reg       <= 1'b0;
            soc_rst_n_reg <= 1'b0;
            btn_prev_reg  <= 1'b1;
            cause_reg     <= 5'b1 << CAUSE_POR;
            count_reg     <= 8'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            fsb_reg       <= fsb_next;
            soc_rst_n_reg <= (state_next != ST_ASSERT);
            btn_prev_reg  <= btn_level;
            cause_reg     <= cause_next;
            count_reg     <= count_next;
        end
    end

    always_comb begin
        csr_do = 8'h00;
        if (hit_cause) begin
            csr_do = {3'b000, cause_reg};
        end else if (hit_count) begin
            csr_do = count_reg;
        end
    end

    assign soc_rst_n     = soc_rst_n_reg;
    assign failsafe_boot = fsb_reg;
    assign rst_active    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_reset_ctrl.sv
// Directed bench for reset_ctrl; debounce checks compile in when
// RESET_CTRL_DEBOUNCE_EN is defined.
module tb_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b0;
    logic       pwr_is_off = 1'b0;
    logic [4:0] csr_a = 5'h0;
    logic [7:0] csr_di = 8'h0;
    logic       csr_we = 1'b0;
    logic [7:0] csr_do;
    logic [1:0] wdt_strobe = 2'b00;
    logic       failsafe_mode = 1'b0;
    logic       btn_rst_n = 1'b1;
    logic       soc_rst_n;
    logic       failsafe_boot;
    logic       rst_active;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    reset_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .pwr_is_off    (pwr_is_off),
        .csr_a         (csr_a),
        .csr_di        (csr_di),
        .csr_we        (csr_we),
        .csr_do        (csr_do),
        .wdt_strobe    (wdt_strobe),
        .failsafe_mode (failsafe_mode),
        .btn_rst_n     (btn_rst_n),
        .soc_rst_n     (soc_rst_n),
        .failsafe_boot (failsafe_boot),
        .rst_active    (rst_active)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ce_steps(input int n);
        for (int i = 0; i < n; i++) begin
            ce = 1'b1;
            step();
        end
        ce = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [7:0] d);
        csr_a = a;
        #1;
        d = csr_do;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        step();
        csr_we = 1'b0;
    endtask

    task automatic run_to_idle(input string tag);
        int n;
        n = 0;
        ce = 1'b1;
        while (rst_active && n < 2000) begin
            step();
            n++;
        end
        ce = 1'b0;
        if (rst_active) chk({tag, "_timeout"}, 8'(rst_active), 8'd0);
    endtask

    task automatic trig_wdt(input logic [1:0] w);
        wdt_strobe = w;
        step();
        wdt_strobe = 2'b00;
    endtask

    initial begin
        logic [7:0] d;

        // reset state and the first timed pulse, ce every other clock
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_soc_rst_n", 8'(soc_rst_n), 8'd0);
        chk("rst_active", 8'(rst_active), 8'd1);
        chk("rst_failsafe", 8'(failsafe_boot), 8'd0);
        rd(5'h0, d); chk("rst_cause", d, 8'h10);
        rd(5'h2, d); chk("rst_count", d, 8'h00);
        for (int i = 0; i < 99; i++) begin
            ce = 1'b1; step();
            ce = 1'b0; step();
        end
        chk("pulse_99ce_low", 8'(soc_rst_n), 8'd0);
        ce = 1'b1; step(); ce = 1'b0;
        chk("pulse_100ce_high", 8'(soc_rst_n), 8'd1);
        chk("holdoff_active", 8'(rst_active), 8'd1);
        ce_steps(19);
        chk("holdoff_19ce", 8'(rst_active), 8'd1);
        ce_steps(1);
        chk("holdoff_done", 8'(rst_active), 8'd0);

        // watchdog bite latches failsafe selection
        failsafe_mode = 1'b1;
        trig_wdt(2'b10);
        chk("wdt1_soc_rst_n", 8'(soc_rst_n), 8'd0);
        chk("wdt1_failsafe", 8'(failsafe_boot), 8'd1);
        rd(5'h0, d); chk("wdt1_cause", d, 8'h12);
        rd(5'h2, d); chk("wdt1_count", d, 8'h01);

        // software reset during HOLDOFF only records
        failsafe_mode = 1'b0;
        ce_steps(100);
        chk("wdt1_in_holdoff", 8'(soc_rst_n), 8'd1);
        wr(5'h1, 8'hc5);
        chk("sw_holdoff_no_pulse", 8'(soc_rst_n), 8'd1);
        chk("sw_holdoff_failsafe_held", 8'(failsafe_boot), 8'd1);
        rd(5'h0, d); chk("sw_holdoff_cause", d, 8'h1a);
        rd(5'h2, d); chk("sw_holdoff_count", d, 8'h02);
        run_to_idle("sw_holdoff");

        // wrong key ignored, right key pulses, clear vs set
        wr(5'h0, 8'hff);
        rd(5'h0, d); chk("cause_cleared", d, 8'h00);
        wr(5'h1, 8'h00);
        chk("badkey_idle", 8'(rst_active), 8'd0);
        rd(5'h2, d); chk("badkey_count", d, 8'h02);
        wr(5'h1, 8'hc5);
        chk("sw_pulse", 8'(soc_rst_n), 8'd0);
        chk("sw_failsafe", 8'(failsafe_boot), 8'd0);
        rd(5'h0, d); chk("sw_cause", d, 8'h08);
        rd(5'h2, d); chk("sw_count", d, 8'h03);
        run_to_idle("sw");
        csr_a = 5'h0; csr_di = 8'h1f; csr_we = 1'b1; wdt_strobe = 2'b01;
        step();
        csr_we = 1'b0; wdt_strobe = 2'b00;
        rd(5'h0, d); chk("clr_vs_set_cause", d, 8'h01);
        rd(5'h2, d); chk("clr_vs_set_count", d, 8'h04);
        run_to_idle("clr_vs_set");

        // button press
`ifdef RESET_CTRL_DEBOUNCE_EN
        btn_rst_n = 1'b0;
        ce_steps(5);
        btn_rst_n = 1'b1;
        ce_steps(20);
        chk("btn_glitch_ignored", 8'(rst_active), 8'd0);
        btn_rst_n = 1'b0;
        ce_steps(14);
        chk("btn_debounced_press", 8'(rst_active), 8'd1);
        btn_rst_n = 1'b1;
`else
        btn_rst_n = 1'b0;
        step();
        step();
        chk("btn_sync_latency", 8'(rst_active), 8'd0);
        step();
        chk("btn_press", 8'(soc_rst_n), 8'd0);
        btn_rst_n = 1'b1;
`endif
        rd(5'h0, d); chk("btn_cause", d, 8'h05);
        rd(5'h2, d); chk("btn_count", d, 8'h05);
        run_to_idle("btn");

        // power-off override during HOLDOFF
        trig_wdt(2'b01);
        ce_steps(100);
        chk("pwr_pre_holdoff", 8'(soc_rst_n), 8'd1);
        pwr_is_off = 1'b1;
        ce_steps(5);
        chk("pwr_forces_reset", 8'(soc_rst_n), 8'd0);
        pwr_is_off = 1'b0;
        ce_steps(99);
        chk("pwr_99ce_low", 8'(soc_rst_n), 8'd0);
        ce_steps(1);
        chk("pwr_100ce_high", 8'(soc_rst_n), 8'd1);
        rd(5'h0, d); chk("pwr_no_cause", d, 8'h05);
        rd(5'h2, d); chk("pwr_count", d, 8'h06);
        run_to_idle("pwr");

        // count saturation and clear
        wr(5'h2, 8'h00);
        rd(5'h2, d); chk("count_clear", d, 8'h00);
        for (int i = 0; i < 300; i++) begin
            trig_wdt(2'b01);
            run_to_idle("sat");
        end
        rd(5'h2, d); chk("count_saturated", d, 8'hff);
        csr_a = 5'h2; csr_di = 8'h00; csr_we = 1'b1; wdt_strobe = 2'b01;
        step();
        csr_we = 1'b0; wdt_strobe = 2'b00;
        rd(5'h2, d); chk("count_clear_vs_inc", d, 8'h01);
        run_to_idle("clr_inc");
        wr(5'h2, 8'h55);
        rd(5'h2, d); chk("count_write_clear", d, 8'h00);
        rd(5'h1, d); chk("swrst_reads_zero", d, 8'h00);
        rd(5'h7, d); chk("unmapped_zero", d, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
